fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised fetch stage for the pipelined LEGv8 core. It replaces the bare IF/ID flop with a PC register plus a
//   DEPTH-entry instruction prefetch FIFO. It drives the instruction-memory address and hands {pc, instr} to decode
//   with valid/stall handshaking. A taken branch from EX (PCSrc/PCBranch_E) redirects the PC and flushes the queue.
// PARAMETERS
//   N        64  datapath / PC width in bits
//   DEPTH    4   queue entries, power of 2, >=2
//   RESET_PC 0   PC value loaded on reset (N bits)
// PORTS
//   clk          in   1        clock, all state updates on rising edge
//   reset        in   1        asynchronous active-low reset (0 = reset)
//   IM_addr      out  N        instruction-memory byte address (= PC register)
//   IM_readData  in   32       instruction at IM_addr, combinational (same cycle)
//   PCSrc        in   1        branch taken in EX: redirect + flush
//   PCBranch_E   in   N        redirect target, sampled when PCSrc=1
//   stall_D      in   1        decode cannot accept this cycle
//   valid_D      out  1        head entry valid
//   instr_D      out  32       head instruction (32'h0 when !valid_D)
//   pc_D         out  N        PC of head instruction (0 when !valid_D)
//   count        out  clog2(DEPTH+1)  occupied entries, 0..DEPTH
//   stall_cnt    out  32       cycles with valid_D=1 and stall_D=1, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//   Reset (reset=0, async): PC=RESET_PC, rd/wr ptr=0, count=0, valid_D=0, instr_D=0, pc_D=0, stall_cnt=0.
//   pop  = valid_D & ~stall_D & ~PCSrc.
//   push = ~PCSrc & (count<DEPTH | pop).
//   On push, write {PC, IM_readData} at wr_ptr, PC<=PC+4, wr_ptr++ (mod DEPTH).
//   On no push and no redirect, PC holds.
//   On pop, rd_ptr++ (mod DEPTH).
//   count <= count + push - pop.
//   Push and pop may occur together, including when full (count stays DEPTH) or at count=1.
//   Latency: an instruction fetched in cycle t is at the head no earlier than t+1. No same-cycle bypass to decode.
//   Redirect (PCSrc=1) has priority over everything:
//     - PC<=PCBranch_E; ptrs=0; count=0; no push, no pop that cycle.
//     - Entry in decode that cycle is discarded.
//     - Next cycle: valid_D=0, IM_addr=PCBranch_E.
//     - First target instruction appears at the head 2 cycles after PCSrc.
//   Full (count=DEPTH) with no pop: no push, PC and IM_addr held stable.
//   Empty (count=0): valid_D=0, instr_D=0, pc_D=0. pop is impossible.
//   Pointer wrap: ptrs are clog2(DEPTH) bits and wrap naturally. count disambiguates full from empty.
//   PC arithmetic: N-bit unsigned, wraps modulo 2^N. Bits [1:0] are not checked.
//   stall_cnt: increments when valid_D & stall_D & ~PCSrc. Holds at max. Cleared only by reset.
//   Reset asserted mid-operation: all state clears immediately, regardless of clk.
//     First fetch at RESET_PC on the first edge after release.
//   Outputs are registered or decoded from registered state only. No combinational path IM_readData->instr_D.
// TESTING
//   1 Reset, imem[k]=k+0x100, stall_D=0
//       -> IM_addr 0,4,8,... per cycle; valid_D from cycle 1;
//          instr_D 0x100,0x101,... with pc_D 0,4,...; count steady at 1.
//   2 stall_D=1 held 10 cycles, DEPTH=4
//       -> count climbs to 4 then holds; IM_addr frozen at 16; stall_cnt=10;
//          release -> 4 pops in order, no loss or duplicate.
//   3 Full queue, stall_D=0 for one cycle
//       -> simultaneous push+pop, count stays 4, PC advances by 4.
//   4 PCSrc=1, PCBranch_E=0x40 with 3 entries queued
//       -> next cycle count=0, valid_D=0, IM_addr=0x40;
//          2 cycles later instr_D=imem[16], pc_D=0x40.
//   5 PCSrc=1 coincident with stall_D=1 and a full queue
//       -> flush wins; stall_cnt not incremented that cycle.
//   6 reset pulsed low between edges mid-stream
//       -> outputs clear immediately; refetch from RESET_PC; pointer wrap checked past 2*DEPTH pushes.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage: PC register feeding a DEPTH-entry prefetch FIFO of {pc, instr} pairs for decode.
// A taken branch from EX redirects the PC and empties the queue in the same cycle.
module fetch_queue #(
    parameter int            N        = 64,
    parameter int            DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [N-1:0]                 IM_addr,
    input  logic [31:0]                  IM_readData,
    input  logic                         PCSrc,
    input  logic [N-1:0]                 PCBranch_E,
    input  logic                         stall_D,
    output logic                         valid_D,
    output logic [31:0]                  instr_D,
    output logic [N-1:0]                 pc_D,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [31:0]                  stall_cnt
);

    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [N-1:0]   r_pc;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_stall_cnt;
    logic [N-1:0]   r_pc_mem  [DEPTH];
    logic [31:0]    r_ins_mem [DEPTH];

    logic           w_valid;
    logic           w_pop;
    logic           w_push;
    logic [CW-1:0]  w_push_ext;
    logic [CW-1:0]  w_pop_ext;

    // Handshake: decode consumes the head on any cycle where valid_D=1 and stall_D=0,
    // unless PCSrc=1, in which case the head is discarded along with the rest of the queue.
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid & ~stall_D & ~PCSrc;
    assign w_push     = ~PCSrc & ((r_count != FULL) | w_pop);
    assign w_push_ext = {{(CW-1){1'b0}}, w_push};
    assign w_pop_ext  = {{(CW-1){1'b0}}, w_pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_stall_cnt <= '0;
        end else if (PCSrc) begin
            r_pc     <= PCBranch_E;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + N'(4);
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + w_push_ext - w_pop_ext;
            if (w_valid && stall_D && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    // Storage needs no reset: entries are only observed through the valid-gated head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_pc;
            r_ins_mem[r_wr_ptr] <= IM_readData;
        end
    end

    assign IM_addr   = r_pc;
    assign valid_D   = w_valid;
    assign instr_D   = w_valid ? r_ins_mem[r_rd_ptr] : 32'h0;
    assign pc_D      = w_valid ? r_pc_mem[r_rd_ptr] : '0;
    assign count     = r_count;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random stall/redirect/reset traffic,
// checked against a queue-based fetch model and a negedge monitor on decode pops.
module tb_fetch_queue;

    localparam int           N        = 64;
    localparam int           DEPTH    = 4;
    localparam logic [N-1:0] RESET_PC = 64'h0;

    logic          clk;
    logic          reset;
    logic [N-1:0]  IM_addr;
    logic [31:0]   IM_readData;
    logic          PCSrc;
    logic [N-1:0]  PCBranch_E;
    logic          stall_D;
    logic          valid_D;
    logic [31:0]   instr_D;
    logic [N-1:0]  pc_D;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [31:0]   stall_cnt;

    fetch_queue #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .IM_addr(IM_addr), .IM_readData(IM_readData),
        .PCSrc(PCSrc), .PCBranch_E(PCBranch_E), .stall_D(stall_D),
        .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D),
        .count(count), .stall_cnt(stall_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // instruction memory: word k holds k + 0x100
    function automatic logic [31:0] imem(input logic [N-1:0] a);
        return a[33:2] + 32'h100;
    endfunction

    assign IM_readData = imem(IM_addr);

    // reference model state and scoreboard
    logic [N+31:0] exp_q[$];
    logic [N-1:0]  m_pc;
    int            m_cnt;
    logic [31:0]   m_sc;
    int            total;
    int            bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every decode pop must present the oldest fetched, not-yet-consumed entry
    always @(negedge clk) begin
        logic [N+31:0] e;
        if (reset && valid_D && !stall_D && !PCSrc) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_empty: got pc %h with nothing expected", pc_D);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", pc_D, e[N+31:32]);
                chk("pop_instr", 64'(instr_D), 64'(e[31:0]));
            end
        end
    end

    // one cycle: check current outputs against the model, drive inputs, advance the model
    task automatic cycle(input logic st, input logic ps, input logic [N-1:0] tgt);
        bit pop, push;
        chk("IM_addr", IM_addr, m_pc);
        chk("count", 64'(count), 64'(m_cnt));
        chk("valid_D", 64'(valid_D), 64'(m_cnt != 0));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
        if (m_cnt == 0) begin
            chk("empty_instr", 64'(instr_D), 64'h0);
            chk("empty_pc", pc_D, 64'h0);
        end
        stall_D    = st;
        PCSrc      = ps;
        PCBranch_E = tgt;
        pop  = (m_cnt > 0) && !st && !ps;
        push = !ps && ((m_cnt < DEPTH) || pop);
        if (ps) begin
            exp_q.delete();
            m_cnt = 0;
            m_pc  = tgt;
        end else begin
            if (m_cnt > 0 && st && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (push) begin
                exp_q.push_back({m_pc, imem(m_pc)});
                m_pc = m_pc + 64'd4;
            end
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
        @(posedge clk);
        #2;
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        stall_D = 1'b0;
        PCSrc   = 1'b0;
        reset   = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_valid", 64'(valid_D), 64'h0);
        chk("rst_addr", IM_addr, RESET_PC);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        chk("rst_instr", 64'(instr_D), 64'h0);
        chk("rst_pc", pc_D, 64'h0);
        m_pc  = RESET_PC;
        m_cnt = 0;
        m_sc  = '0;
        exp_q.delete();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        stall_D = 1'b0;
        PCSrc = 1'b0;
        PCBranch_E = '0;
        m_pc  = RESET_PC;
        m_cnt = 0;
        m_sc  = '0;
        #1;
        chk("init_count", 64'(count), 64'h0);
        chk("init_valid", 64'(valid_D), 64'h0);
        chk("init_addr", IM_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        // streaming with no stalls
        repeat (6) cycle(1'b0, 1'b0, '0);
        // held stall fills the queue, then one push+pop at full, then drain
        repeat (10) cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        repeat (6) cycle(1'b0, 1'b0, '0);
        // redirect with three entries queued
        repeat (2) cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 64'h40);
        repeat (4) cycle(1'b0, 1'b0, '0);
        // redirect coinciding with stall on a full queue
        repeat (6) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 64'h80);
        repeat (3) cycle(1'b0, 1'b0, '0);
        // PC wraps past 2^64
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (5) cycle(1'b0, 1'b0, '0);
        // reset mid-stream, then well past 2*DEPTH pushes
        repeat (3) cycle(1'b0, 1'b0, '0);
        pulse_reset();
        repeat (16) cycle(1'($urandom_range(0, 1)), 1'b0, '0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                cycle(1'($urandom_range(0, 99) < 40),
                      1'($urandom_range(0, 99) < 6),
                      {$urandom, $urandom});
            end
        end
        repeat (8) cycle(1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
